// File: rtl/smutex_lock_engine_if.sv
// Request/response bus between the register block and the lock engine.
// The master drives the access and the slave answers with a one-cycle response strobe.
interface smutex_lock_engine_if #(
  parameter int ID_W = 6
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [4:0]      req_idx;
  logic [ID_W-1:0] req_id;
  logic [31:0]     req_wdata;
  logic            rsp_valid;
  logic [ID_W-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_write, req_idx, req_id, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_idx, req_id, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/smutex_lock_engine.sv
// Mutex owner table with acquire/release arbitration, hold-timeout watchdogs and error logging.
// Latency 2 cycles accept->rsp_valid; req_ready is low from accept until the response cycle ends.
module smutex_lock_engine #(
  parameter int NUM_MUTEX = 32,
  parameter int ID_W      = 6
) (
  input  logic                clk,
  input  logic                rst,
  smutex_lock_engine_if.slave bus,
  input  logic [7:0]          timeout_compare_q,
  input  logic [1:0]          timeout_prescale_q,
  input  logic [2:0]          err_code_q,
  output logic [2:0]          err_code_d,
  output logic                err_code_enb,
  output logic                err_access_d,
  output logic                err_access_enb,
  output logic [ID_W-1:0]     err_id_d,
  output logic                err_id_enb,
  output logic                err_multi_d,
  output logic                err_multi_enb,
  output logic [31:0]         err_data_d,
  output logic                err_data_enb,
  output logic [4:0]          err_idx_d,
  output logic                err_idx_enb
);

  localparam int SLOTS = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

  typedef struct packed {
    logic            write;
    logic [4:0]      idx;
    logic [ID_W-1:0] id;
    logic [31:0]     wdata;
  } req_t;

  state_t          state_q, state_d;
  req_t            req_q;
  logic [ID_W-1:0] rdata_q;
  logic            rsp_err_q;

  // Sized to the full 5-bit index space; slots at or above NUM_MUTEX stay zero.
  logic [ID_W-1:0] owner_q [SLOTS];
  logic [7:0]      age_q   [SLOTS];

  logic [11:0] pre_cnt_q;
  logic [11:0] pre_max;
  logic [1:0]  pre_sel_q;
  logic        tick;

  logic            to_hit;
  logic [4:0]      to_idx;
  logic            exec;
  logic            idx_ok;
  logic [ID_W-1:0] eff_owner;
  logic            acq_ok;
  logic            rel_ok;
  logic [2:0]      req_code;
  logic            req_err;
  logic [ID_W-1:0] rdata_next;

  // Tick generator; a prescale change restarts the count from zero.
  always_comb begin
    pre_max = 12'd0;
    case (timeout_prescale_q)
      2'd0:    pre_max = 12'd0;
      2'd1:    pre_max = 12'd15;
      2'd2:    pre_max = 12'd255;
      default: pre_max = 12'd4095;
    endcase
  end

  assign tick = (pre_sel_q == timeout_prescale_q) && (pre_cnt_q == pre_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= 12'd0;
      pre_sel_q <= 2'd0;
    end else begin
      pre_sel_q <= timeout_prescale_q;
      if ((pre_sel_q != timeout_prescale_q) || (pre_cnt_q == pre_max))
        pre_cnt_q <= 12'd0;
      else
        pre_cnt_q <= pre_cnt_q + 12'd1;
    end
  end

  // Descending scan so the lowest expiring slot wins.
  always_comb begin
    to_hit = 1'b0;
    to_idx = 5'd0;
    for (int i = NUM_MUTEX - 1; i >= 0; i--) begin
      if ((owner_q[i] != '0) && (timeout_compare_q != 8'd0) &&
          (age_q[i] >= timeout_compare_q)) begin
        to_hit = 1'b1;
        to_idx = 5'(i);
      end
    end
  end

  assign exec   = (state_q == ST_EXEC);
  assign idx_ok = ({27'd0, req_q.idx} < 32'(NUM_MUTEX));

  // A same-cycle forced release is visible to the access.
  always_comb begin
    eff_owner = '0;
    if (idx_ok && !(to_hit && (to_idx == req_q.idx)))
      eff_owner = owner_q[req_q.idx];
  end

  assign acq_ok = exec && idx_ok && !req_q.write && (req_q.id != '0) && (eff_owner == '0);
  assign rel_ok = exec && idx_ok && req_q.write && (req_q.wdata == 32'd0) &&
                  (eff_owner == req_q.id);

  always_comb begin
    req_code = 3'd0;
    if (!idx_ok)
      req_code = 3'd4;
    else if (!req_q.write)
      req_code = (req_q.id == '0) ? 3'd5 : 3'd0;
    else if (req_q.wdata != 32'd0)
      req_code = 3'd2;
    else if ((eff_owner != '0) && (eff_owner != req_q.id))
      req_code = 3'd1;
  end

  assign req_err = exec && (req_code != 3'd0);

  always_comb begin
    rdata_next = eff_owner;
    if (!idx_ok)     rdata_next = '0;
    else if (acq_ok) rdata_next = req_q.id;
    else if (rel_ok) rdata_next = '0;
  end

  always_comb begin
    err_code_d     = 3'd0;
    err_code_enb   = 1'b0;
    err_access_d   = 1'b0;
    err_access_enb = 1'b0;
    err_id_d       = '0;
    err_id_enb     = 1'b0;
    err_multi_d    = 1'b0;
    err_multi_enb  = 1'b0;
    err_data_d     = 32'd0;
    err_data_enb   = 1'b0;
    err_idx_d      = 5'd0;
    err_idx_enb    = 1'b0;
    if (req_err || to_hit) begin
      err_multi_enb = 1'b1;
      if (err_code_q != 3'd0) begin
        err_multi_d = 1'b1;
      end else begin
        err_code_enb   = 1'b1;
        err_access_enb = 1'b1;
        err_id_enb     = 1'b1;
        err_data_enb   = 1'b1;
        err_idx_enb    = 1'b1;
        err_multi_d    = req_err && to_hit;
        if (req_err) begin
          err_code_d   = req_code;
          err_access_d = req_q.write;
          err_id_d     = req_q.id;
          err_data_d   = req_q.wdata;
          err_idx_d    = req_q.idx;
        end else begin
          err_code_d   = 3'd3;
          err_access_d = 1'b0;
          err_id_d     = owner_q[to_idx];
          err_data_d   = 32'd0;
          err_idx_d    = to_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        owner_q[i] <= '0;
        age_q[i]   <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NUM_MUTEX; i++) begin
        if (acq_ok && (req_q.idx == 5'(i))) begin
          owner_q[i] <= req_q.id;
          age_q[i]   <= 8'd0;
        end else if ((rel_ok && (req_q.idx == 5'(i))) || (to_hit && (to_idx == 5'(i)))) begin
          owner_q[i] <= '0;
          age_q[i]   <= 8'd0;
        end else if (tick && (owner_q[i] != '0) && (age_q[i] != 8'hff)) begin
          age_q[i] <= age_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && bus.req_valid) begin
        req_q.write <= bus.req_write;
        req_q.idx   <= bus.req_idx;
        req_q.id    <= bus.req_id;
        req_q.wdata <= bus.req_wdata;
      end
      if (exec) begin
        rdata_q   <= rdata_next;
        rsp_err_q <= req_err;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
  assign bus.rsp_err   = (state_q == ST_RESP) && rsp_err_q;

endmodule

// File: tb/tb_smutex_lock_engine.sv
// Directed bench for smutex_lock_engine: acquire/release, error logging, watchdog and reset abort.
module tb_smutex_lock_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0]  timeout_compare_q  = 8'd0;
  logic [1:0]  timeout_prescale_q = 2'd0;
  logic [2:0]  err_code_q         = 3'd0;
  logic [2:0]  err_code_d;
  logic        err_code_enb;
  logic        err_access_d, err_access_enb;
  logic [5:0]  err_id_d;
  logic        err_id_enb;
  logic        err_multi_d, err_multi_enb;
  logic [31:0] err_data_d;
  logic        err_data_enb;
  logic [4:0]  err_idx_d;
  logic        err_idx_enb;

  int checks = 0;
  int errors = 0;

  // Results captured by do_req
  logic        r_rdy_idle, r_rdy_exec, r_vld, r_err;
  logic [5:0]  r_rdata;
  logic [2:0]  c_code_d;
  logic        c_code_enb, c_access_d, c_multi_d, c_multi_enb, c_data_enb;
  logic [5:0]  c_id_d;
  logic [31:0] c_data_d;
  logic [4:0]  c_idx_d;

  smutex_lock_engine_if #(.ID_W(6)) bus ();

  smutex_lock_engine #(.NUM_MUTEX(16), .ID_W(6)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus.slave),
    .timeout_compare_q  (timeout_compare_q),
    .timeout_prescale_q (timeout_prescale_q),
    .err_code_q         (err_code_q),
    .err_code_d         (err_code_d),
    .err_code_enb       (err_code_enb),
    .err_access_d       (err_access_d),
    .err_access_enb     (err_access_enb),
    .err_id_d           (err_id_d),
    .err_id_enb         (err_id_enb),
    .err_multi_d        (err_multi_d),
    .err_multi_enb      (err_multi_enb),
    .err_data_d         (err_data_d),
    .err_data_enb       (err_data_enb),
    .err_idx_d          (err_idx_d),
    .err_idx_enb        (err_idx_enb)
  );

  always #5 clk = ~clk;

  task automatic do_req(input logic wr, input logic [4:0] idx, input logic [5:0] id,
                        input logic [31:0] wd);
    @(negedge clk);
    r_rdy_idle    = bus.req_ready;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_idx   = idx;
    bus.req_id    = id;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    r_rdy_exec    = bus.req_ready;
    c_code_enb    = err_code_enb;
    c_code_d      = err_code_d;
    c_access_d    = err_access_d;
    c_id_d        = err_id_d;
    c_data_d      = err_data_d;
    c_data_enb    = err_data_enb;
    c_idx_d       = err_idx_d;
    c_multi_d     = err_multi_d;
    c_multi_enb   = err_multi_enb;
    @(negedge clk);
    r_vld   = bus.rsp_valid;
    r_rdata = bus.rsp_rdata;
    r_err   = bus.rsp_err;
  endtask

  task automatic test_reset();
    logic [5:0] enbs;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_idx   = 5'd0;
    bus.req_id    = 6'd0;
    bus.req_wdata = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    enbs = {err_code_enb, err_access_enb, err_id_enb, err_multi_enb, err_data_enb, err_idx_enb};
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 6'd0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp: rdata %0d err %b want 0/0", bus.rsp_rdata, bus.rsp_err); end
    checks++; if (enbs !== 6'd0) begin errors++; $display("FAIL rst_enb: got %b want 000000", enbs); end
    checks++; if (err_code_d !== 3'd0 || err_data_d !== 32'd0 || err_id_d !== 6'd0) begin errors++; $display("FAIL rst_d: code %0d data %h id %0d want 0", err_code_d, err_data_d, err_id_d); end
    rst = 1'b0;
  endtask

  task automatic test_acquire();
    do_req(1'b0, 5'd3, 6'd5, 32'd0);
    checks++; if (r_rdy_idle !== 1'b1 || r_rdy_exec !== 1'b0) begin errors++; $display("FAIL acq_ready: idle %b exec %b want 1/0", r_rdy_idle, r_rdy_exec); end
    checks++; if (r_vld !== 1'b1) begin errors++; $display("FAIL acq_latency: rsp_valid %b want 1", r_vld); end
    checks++; if (r_rdata !== 6'd5 || r_err !== 1'b0) begin errors++; $display("FAIL acq_free: rdata %0d err %b want 5/0", r_rdata, r_err); end
    do_req(1'b0, 5'd3, 6'd9, 32'd0);
    checks++; if (r_rdata !== 6'd5 || r_err !== 1'b0 || c_code_enb !== 1'b0) begin errors++; $display("FAIL acq_busy: rdata %0d err %b enb %b want 5/0/0", r_rdata, r_err, c_code_enb); end
  endtask

  task automatic test_release();
    do_req(1'b1, 5'd3, 6'd9, 32'd0);
    checks++; if (c_code_enb !== 1'b1 || c_code_d !== 3'd1) begin errors++; $display("FAIL rel_code: enb %b code %0d want 1/1", c_code_enb, c_code_d); end
    checks++; if (c_id_d !== 6'd9 || c_idx_d !== 5'd3 || c_access_d !== 1'b1) begin errors++; $display("FAIL rel_fields: id %0d idx %0d acc %b want 9/3/1", c_id_d, c_idx_d, c_access_d); end
    checks++; if (c_multi_enb !== 1'b1 || c_multi_d !== 1'b0) begin errors++; $display("FAIL rel_multi: enb %b d %b want 1/0", c_multi_enb, c_multi_d); end
    checks++; if (r_err !== 1'b1 || r_rdata !== 6'd5) begin errors++; $display("FAIL rel_nonowner: err %b rdata %0d want 1/5", r_err, r_rdata); end
    do_req(1'b1, 5'd3, 6'd5, 32'd0);
    checks++; if (r_rdata !== 6'd0 || r_err !== 1'b0 || c_code_enb !== 1'b0) begin errors++; $display("FAIL rel_owner: rdata %0d err %b enb %b want 0/0/0", r_rdata, r_err, c_code_enb); end
  endtask

  task automatic test_bad_write();
    do_req(1'b1, 5'd2, 6'd1, 32'h1234);
    checks++; if (c_code_d !== 3'd2 || c_data_d !== 32'h1234 || c_access_d !== 1'b1) begin errors++; $display("FAIL wdata_log: code %0d data %h acc %b want 2/1234/1", c_code_d, c_data_d, c_access_d); end
    checks++; if (r_err !== 1'b1 || c_data_enb !== 1'b1) begin errors++; $display("FAIL wdata_err: err %b data_enb %b want 1/1", r_err, c_data_enb); end
    err_code_q = 3'd2;
    do_req(1'b1, 5'd2, 6'd1, 32'd5);
    checks++; if (c_code_enb !== 1'b0 || c_data_enb !== 1'b0) begin errors++; $display("FAIL multi_keep: code_enb %b data_enb %b want 0/0", c_code_enb, c_data_enb); end
    checks++; if (c_multi_enb !== 1'b1 || c_multi_d !== 1'b1 || r_err !== 1'b1) begin errors++; $display("FAIL multi_set: enb %b d %b err %b want 1/1/1", c_multi_enb, c_multi_d, r_err); end
    err_code_q = 3'd0;
  endtask

  task automatic test_range();
    do_req(1'b0, 5'd31, 6'd4, 32'd0);
    checks++; if (c_code_d !== 3'd4 || c_idx_d !== 5'd31) begin errors++; $display("FAIL range_code: code %0d idx %0d want 4/31", c_code_d, c_idx_d); end
    checks++; if (r_rdata !== 6'd0 || r_err !== 1'b1) begin errors++; $display("FAIL range_rsp: rdata %0d err %b want 0/1", r_rdata, r_err); end
    do_req(1'b0, 5'd5, 6'd0, 32'd0);
    checks++; if (c_code_d !== 3'd5 || c_access_d !== 1'b0 || r_err !== 1'b1 || r_rdata !== 6'd0) begin errors++; $display("FAIL id0: code %0d acc %b err %b rdata %0d want 5/0/1/0", c_code_d, c_access_d, r_err, r_rdata); end
  endtask

  task automatic test_timeout();
    int   n;
    logic seen;
    logic [2:0]  t_code;
    logic [5:0]  t_id;
    logic [4:0]  t_idx;
    logic        t_acc;
    logic [31:0] t_data;
    timeout_compare_q  = 8'd4;
    timeout_prescale_q = 2'd1;
    do_req(1'b0, 5'd10, 6'd7, 32'd0);
    checks++; if (r_rdata !== 6'd7) begin errors++; $display("FAIL to_lock: rdata %0d want 7", r_rdata); end
    seen = 1'b0;
    n = 0;
    t_code = 3'd0; t_id = 6'd0; t_idx = 5'd0; t_acc = 1'b1; t_data = 32'hffff_ffff;
    while (!seen && n < 120) begin
      @(negedge clk);
      n++;
      if (err_code_enb === 1'b1) begin
        seen = 1'b1;
        t_code = err_code_d; t_id = err_id_d; t_idx = err_idx_d;
        t_acc = err_access_d; t_data = err_data_d;
      end
    end
    checks++; if (!seen || n < 45 || n > 70) begin errors++; $display("FAIL to_window: seen %b after %0d cycles want 1 within 45..70", seen, n); end
    checks++; if (t_code !== 3'd3 || t_id !== 6'd7 || t_idx !== 5'd10) begin errors++; $display("FAIL to_fields: code %0d id %0d idx %0d want 3/7/10", t_code, t_id, t_idx); end
    checks++; if (t_acc !== 1'b0 || t_data !== 32'd0) begin errors++; $display("FAIL to_acc_data: acc %b data %h want 0/0", t_acc, t_data); end
    @(negedge clk);
    checks++; if (err_code_enb !== 1'b0) begin errors++; $display("FAIL to_once: enb %b want 0", err_code_enb); end
    timeout_compare_q = 8'd0;
    do_req(1'b0, 5'd10, 6'd8, 32'd0);
    checks++; if (r_rdata !== 6'd8 || r_err !== 1'b0) begin errors++; $display("FAIL to_reacq: rdata %0d err %b want 8/0", r_rdata, r_err); end
  endtask

  task automatic test_reset_mid();
    logic saw_vld;
    do_req(1'b0, 5'd6, 6'd3, 32'd0);
    checks++; if (r_rdata !== 6'd3) begin errors++; $display("FAIL mid_pre: rdata %0d want 3", r_rdata); end
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_idx   = 5'd7;
    bus.req_id    = 6'd2;
    bus.req_wdata = 32'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    saw_vld = 1'b0;
    repeat (3) begin
      #1;
      if (bus.rsp_valid === 1'b1) saw_vld = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", bus.req_ready); end
    checks++; if (saw_vld !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp: rsp_valid seen %b want 0", saw_vld); end
    do_req(1'b0, 5'd6, 6'd0, 32'd0);
    checks++; if (r_rdata !== 6'd0) begin errors++; $display("FAIL mid_owner6: rdata %0d want 0", r_rdata); end
    do_req(1'b0, 5'd7, 6'd0, 32'd0);
    checks++; if (r_rdata !== 6'd0) begin errors++; $display("FAIL mid_owner7: rdata %0d want 0", r_rdata); end
    do_req(1'b0, 5'd10, 6'd0, 32'd0);
    checks++; if (r_rdata !== 6'd0) begin errors++; $display("FAIL mid_owner10: rdata %0d want 0", r_rdata); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_release();
    test_bad_write();
    test_range();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
